// File: rtl/button_debouncer.sv
// Button debouncer: 2-flop synchronizer, polarity normalization, 4-state debounce FSM with registered level/pulse outputs.
// Optional long-press detector included when BUTTON_DEBOUNCER_LONGPRESS_EN is defined; otherwise o_long is tied low.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          PAD_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, press_nxt, release_nxt;
  logic          sync_a, sync_b;
  logic          s;

  // Synchronizer resets to the released pad level so reset never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_a <= PAD_IDLE;
      sync_b <= PAD_IDLE;
    end else begin
      sync_a <= i_button;
      sync_b <= sync_a;
    end
  end

  assign s = ACTIVE_LOW ? ~sync_b : sync_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_level   <= level_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = o_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = PRESSED;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic [CW-1:0] hold;

  // Hold only clears on a fresh accepted press, so release bounces cannot re-arm o_long.
  // A pulse that would coincide with an accepted release is dropped to keep pulses exclusive.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold   <= '0;
      o_long <= 1'b0;
    end else begin
      o_long <= 1'b0;
      if (state == PRESS_WAIT && state_nxt == PRESSED) begin
        hold <= '0;
      end else if (state == PRESSED || state == RELEASE_WAIT) begin
        if (hold != LONG_MAX) begin
          hold <= hold + CNT_ONE;
        end
        if (hold == LONG_LAST && state_nxt != IDLE) begin
          o_long <= 1'b1;
        end
      end
    end
  end
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic level, press, release_p, long_p;

  int n_run  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int t0;

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_button (button),
    .o_level  (level),
    .o_press  (press),
    .o_release(release_p),
    .o_long   (long_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic check_outs(input string ph, input logic l, input logic p,
                            input logic r, input logic lg);
    chk($sformatf("%s_level@%0d", ph, edge_n), level, l);
    chk($sformatf("%s_press@%0d", ph, edge_n), press, p);
    chk($sformatf("%s_release@%0d", ph, edge_n), release_p, r);
    chk($sformatf("%s_long@%0d", ph, edge_n), long_p, lg);
  endtask

  initial begin
    rst    = 1'b1;
    button = 1'b1;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    while (edge_n < 9) begin
      tick();
      check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Pad low first sampled at edge 10: press after edge 16, long after edge 26.
    button = 1'b0;
    while (edge_n < 39) begin
      tick();
      check_outs("press", edge_n >= 16, edge_n == 16, 1'b0, LONG_EN && (edge_n == 26));
    end

    // Pad high first sampled at edge 40: release after edge 46.
    button = 1'b1;
    while (edge_n < 55) begin
      tick();
      check_outs("release", edge_n < 46, 1'b0, edge_n == 46, 1'b0);
    end

    // Three-cycle glitch is rejected.
    button = 1'b0;
    repeat (3) begin
      tick();
      check_outs("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    button = 1'b1;
    repeat (12) begin
      tick();
      check_outs("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Toggling every cycle while released never gets through.
    repeat (50) begin
      button = ~button;
      tick();
      check_outs("tog_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (8) begin
      tick();
      check_outs("tog_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Second press: first sampled at t0+1, accepted after t0+7.
    t0     = edge_n;
    button = 1'b0;
    while (edge_n < t0 + 9) begin
      tick();
      check_outs("press2", edge_n >= t0 + 7, edge_n == t0 + 7, 1'b0, 1'b0);
    end

    // Reset mid-press: level drops silently, then a full debounce re-runs.
    rst = 1'b1;
    tick();
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    t0  = edge_n;
    while (edge_n < t0 + 20) begin
      tick();
      check_outs("rst_rep", edge_n >= t0 + 7, edge_n == t0 + 7, 1'b0,
                 LONG_EN && (edge_n == t0 + 17));
    end

    // Toggling while pressed never releases.
    repeat (50) begin
      button = ~button;
      tick();
      check_outs("tog_held", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (8) begin
      tick();
      check_outs("tog_held", 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000, SHALL be the number of consecutive stable synchronized samples needed to accept a change; legal range 1 or more.
REQ-002 Parameter LONG_CYCLES, default 27000000, SHALL be the number of PRESSED-state cycles after which a long press is reported; legal range 1 or more.
REQ-003 Parameter ACTIVE_LOW, default 1, SHALL select pad polarity: 1 means pad low = pressed; 0 means pad high = pressed.
REQ-004 i_clk  input  1  SHALL be the single system clock for all flops.
REQ-005 i_rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 i_button  input  1  SHALL be the raw, asynchronous, bouncing button pad.
REQ-007 o_level  output  1  SHALL be the debounced state, active-high = pressed.
REQ-008 o_press  output  1  SHALL be a one-cycle pulse on an accepted press.
REQ-009 o_release  output  1  SHALL be a one-cycle pulse on an accepted release.
REQ-010 o_long  output  1  SHALL be a one-cycle pulse on long-press detection.

Function
REQ-011 i_button SHALL pass through a 2-flop synchronizer, then be polarity-normalized to s (1 = pressed), before any other logic uses it.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, held in a registered state.
REQ-013 IDLE: s=1 SHALL cause a move to PRESS_WAIT and clear the debounce counter; otherwise the FSM stays in IDLE.
REQ-014 PRESS_WAIT: s=0 SHALL cause a return to IDLE with no output change; with s=1 and counter equal to DEBOUNCE_CYCLES-1, the FSM SHALL move to PRESSED and register o_level=1 and o_press=1; otherwise the counter increments.
REQ-015 PRESSED: s=0 SHALL cause a move to RELEASE_WAIT and clear the debounce counter.
REQ-016 RELEASE_WAIT: s=1 SHALL cause a return to PRESSED with no pulse; with s=0 and counter equal to DEBOUNCE_CYCLES-1, the FSM SHALL move to IDLE and register o_level=0 and o_release=1; otherwise the counter increments.
REQ-017 Latency: with the pad stable from clock edge E0, o_press (or o_release) SHALL rise after edge E0+DEBOUNCE_CYCLES+2 and stay high exactly one cycle.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no o_level change.
REQ-019 All outputs SHALL be registered; o_press, o_release and o_long SHALL be mutually exclusive in any cycle.
REQ-020 Counter width SHALL be $clog2 of the larger of DEBOUNCE_CYCLES and LONG_CYCLES, plus 1; counters SHALL saturate and never wrap.

Reset
REQ-021 i_rst SHALL have priority over all other logic.
REQ-022 While i_rst=1: state = IDLE; counters = 0; synchronizer flops = released pad level; o_level, o_press, o_release and o_long = 0.
REQ-023 Reset asserted mid-press SHALL drop o_level with no o_release pulse.
REQ-024 After reset deassertion with the button still held, the block SHALL run a full debounce and then emit o_press.

Configuration
REQ-025 Macro BUTTON_DEBOUNCER_LONGPRESS_EN, when defined, SHALL include a hold counter that clears on entry to PRESSED and increments each PRESSED/RELEASE_WAIT cycle, saturating at LONG_CYCLES.
REQ-026 With the macro defined, o_long SHALL pulse one cycle when the hold count reaches LONG_CYCLES-1, at most once per accepted press; RELEASE_WAIT bounces that return to PRESSED SHALL NOT re-arm o_long.
REQ-027 With the macro undefined, the hold counter SHALL be absent and o_long SHALL be constant 0.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1)
REQ-028 Pad driven low and held from edge 10 -> o_press=1 only in the cycle after edge 16; o_level=1 from the same cycle onward.
REQ-029 Pad low for 3 cycles, then high -> o_press, o_release and o_level stay 0 throughout.
REQ-030 Press accepted, then pad high and held from edge 40 -> o_release=1 only in the cycle after edge 46; o_level=0 afterwards.
REQ-031 Press held 20 cycles with macro defined -> exactly one o_long pulse, 10 cycles after o_press rises; with macro undefined -> o_long always 0.
REQ-032 i_rst=1 for 2 cycles while o_level=1 and pad held low -> outputs 0, no o_release; after deassert, o_press recurs 6 cycles later.
REQ-033 Pad toggling every cycle for 50 cycles -> no pulses, o_level unchanged.
